// File: rtl/fpu_register_file.sv
// fpu_register_file
//   Floating-point architectural register file with its control state:
//   32 x 32-bit registers, the sticky exception flags (fflags), the dynamic
//   rounding mode (frm), and a per-register busy scoreboard.
//
// Ports
//   clk, rst                 : clock and asynchronous active-high reset
//   f_rs1/f_rs2 -> *_data    : combinational reads with write-through bypass
//   f_rd, f_wen, f_w_data    : register write (data already muxed upstream)
//   flags, f_ready           : FPU exception flags {NV,DZ,OF,UF,NX} and valid
//   inst_rm -> frm           : resolved rounding mode, rm_illegal if reserved
//   csr_sel/wen/wdata/rdata  : fflags(01) / frm(10) / fcsr(11) CSR access
//   issue_en, issue_rd       : marks the destination of an issued op busy
//   rs1_busy, rs2_busy       : source register still has a pending write

// One architectural register; instantiated once per register index.
module fpu_reg_entry #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (we) q <= d;
  end
endmodule

module fpu_register_file #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  f_rs1,
  input  logic [4:0]  f_rs2,
  output logic [31:0] f_rs1_data,
  output logic [31:0] f_rs2_data,
  input  logic [4:0]  f_rd,
  input  logic        f_wen,
  input  logic [31:0] f_w_data,
  input  logic [4:0]  flags,
  input  logic        f_ready,
  input  logic [2:0]  inst_rm,
  output logic [2:0]  frm,
  output logic        rm_illegal,
  input  logic [1:0]  csr_sel,
  input  logic        csr_wen,
  input  logic [7:0]  csr_wdata,
  output logic [7:0]  csr_rdata,
  input  logic        issue_en,
  input  logic [4:0]  issue_rd,
  output logic        rs1_busy,
  output logic        rs2_busy
);

  localparam logic [1:0] CSR_NONE   = 2'b00;
  localparam logic [1:0] CSR_FFLAGS = 2'b01;
  localparam logic [1:0] CSR_FRM    = 2'b10;
  localparam logic [1:0] CSR_FCSR   = 2'b11;

  logic [NUM_REGS-1:0][XLEN-1:0] regs;
  logic [NUM_REGS-1:0]           wsel;
  logic [NUM_REGS-1:0]           busy;
  logic [NUM_REGS-1:0]           busy_nxt;
  logic [4:0]                    fflags;
  logic [4:0]                    fflags_base;
  logic [2:0]                    frm_reg;
  logic                          csr_we;
  logic                          byp1, byp2;

  // Register array: one decoded write strobe per entry.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      assign wsel[gi] = f_wen && (f_rd == 5'(gi));
      fpu_reg_entry #(.W(XLEN)) u_ent (
        .clk (clk),
        .rst (rst),
        .we  (wsel[gi]),
        .d   (f_w_data),
        .q   (regs[gi])
      );
    end
  endgenerate

  // Write-through bypass. Suppressed during reset so the outputs show the
  // cleared state rather than an in-flight write that will be discarded.
  assign byp1 = !rst && f_wen && (f_rd == f_rs1);
  assign byp2 = !rst && f_wen && (f_rd == f_rs2);

  assign f_rs1_data = byp1 ? f_w_data : regs[f_rs1];
  assign f_rs2_data = byp2 ? f_w_data : regs[f_rs2];

  // A value being written this cycle is forwarded, so it is not busy.
  assign rs1_busy = busy[f_rs1] & ~byp1;
  assign rs2_busy = busy[f_rs2] & ~byp2;

  // CSR write / sticky flag accumulation. A CSR write replaces the flag
  // base, but flags raised by the FPU in the same cycle are still ORed in
  // so no exception is lost to the collision.
  assign csr_we = csr_wen && (csr_sel != CSR_NONE);

  always_comb begin
    fflags_base = fflags;
    if (csr_we && (csr_sel == CSR_FFLAGS || csr_sel == CSR_FCSR))
      fflags_base = csr_wdata[4:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fflags  <= '0;
      frm_reg <= '0;
    end else begin
      fflags <= fflags_base | (f_ready ? flags : 5'b0);
      if (csr_we && csr_sel == CSR_FRM)  frm_reg <= csr_wdata[2:0];
      if (csr_we && csr_sel == CSR_FCSR) frm_reg <= csr_wdata[7:5];
    end
  end

  always_comb begin
    csr_rdata = 8'h00;
    case (csr_sel)
      CSR_FFLAGS: csr_rdata = {3'b000, fflags};
      CSR_FRM:    csr_rdata = {5'b00000, frm_reg};
      CSR_FCSR:   csr_rdata = {frm_reg, fflags};
      default:    csr_rdata = 8'h00;
    endcase
  end

  // Rounding mode: 111 in the instruction means "use the dynamic mode".
  assign frm        = (inst_rm == 3'b111) ? frm_reg : inst_rm;
  assign rm_illegal = (frm == 3'b101) || (frm == 3'b110) || (frm == 3'b111);

  // Busy scoreboard: clear on writeback, then set on issue so that a new
  // issue to the same register in the same cycle keeps it busy.
  always_comb begin
    busy_nxt = busy;
    if (f_wen)    busy_nxt[f_rd]     = 1'b0;
    if (issue_en) busy_nxt[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

endmodule
